// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes,
// bit-period width and the bit-period helper (tx and rx).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int PRESCALE_W = 16;
  localparam int PERIOD_W   = PRESCALE_W + 3;

  // Bit period in clk cycles; prescale 0 is treated as 1.
  function automatic logic [PERIOD_W-1:0] bit_period(
    input logic [PRESCALE_W-1:0] p
  );
    logic [PRESCALE_W-1:0] q;
    q = (p == '0) ? PRESCALE_W'(1) : p;
    return {q, 3'b000};
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Stream handshake bundle feeding the transmitter.
// Signals: tdata, tvalid (master out), tready (slave out).
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: load latches prescale and restarts the count.
// Ports: clk, rst, load, prescale in; tick, tick_early out.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick,
  output logic                  tick_early
);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;

  // The period is captured only on load, so prescale
  // changes mid-frame are invisible until the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      period <= bit_period('0);
      cnt    <= '0;
    end else if (load) begin
      period <= bit_period(prescale);
      cnt    <= bit_period(prescale) - PERIOD_W'(1);
    end else if (cnt == '0) begin
      cnt    <= period - PERIOD_W'(1);
    end else begin
      cnt    <= cnt - PERIOD_W'(1);
    end
  end

  assign tick       = (cnt == '0);
  // One cycle before terminal count; the final stop bit
  // uses it so its last cycle can double as the IDLE cycle.
  assign tick_early = (cnt == PERIOD_W'(1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop bits.
// Ports: clk, rst, s_axis (slave stream), prescale, txd, busy.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_if.slave              s_axis,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  txd,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH);

  uart_state_t           state_q, state_d;
  logic                  txd_d, busy_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  par_q, par_d;
  logic                  load;
  logic                  tick;
  logic                  tick_early;
  logic                  fire;

  assign fire          = s_axis.tvalid && ready_q;
  assign s_axis.tready = ready_q;

  uart_baud_gen u_baud (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .prescale   (prescale),
    .tick       (tick),
    .tick_early (tick_early)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      txd        <= 1'b1;
      busy       <= 1'b0;
      ready_q    <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd        <= txd_d;
      busy       <= busy_d;
      ready_q    <= ready_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    txd_d      = txd;
    busy_d     = busy;
    ready_d    = ready_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    load       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (fire) begin
          state_d    = ST_START;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          load       = 1'b1;
          shreg_d    = s_axis.tdata;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_d      = (^s_axis.tdata) ^ (PARITY == PAR_ODD);
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            txd_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        // Leave one cycle early: the IDLE cycle is the last
        // stop-bit cycle, so back-to-back frames have no gap.
        if (stop_cnt_q == 1'(STOP_BITS - 1) && tick_early) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          ready_d    = 1'b1;
          stop_cnt_d = 1'b0;
        end else if (tick) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame (5..9).
REQ-002 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-004 Port clk  input  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port s_axis_tdata  input  DATA_WIDTH  byte to transmit.
REQ-007 Port s_axis_tvalid  input  1  upstream data valid.
REQ-008 Port s_axis_tready  output  1  block can accept a byte.
REQ-009 Port prescale  input  16  bit period = prescale*8 clk cycles.
REQ-010 Port txd  output  1  serial line, idle high.
REQ-011 Port busy  output  1  frame in progress.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 Transfer SHALL occur on any cycle with s_axis_tvalid && s_axis_tready; s_axis_tready SHALL be high only in state IDLE.
REQ-014 On transfer, tdata and prescale SHALL be latched; s_axis_tready SHALL drop and busy SHALL rise on the next cycle.
REQ-015 txd SHALL go low (start bit) on the cycle after the transfer: latency exactly 1 cycle.
REQ-016 Frame order SHALL be: start (0), data LSB first, parity (if PARITY!=0), STOP_BITS stop bits (1).
REQ-017 Each bit SHALL last exactly max(prescale,1)*8 cycles; prescale=0 SHALL behave as 1.
REQ-018 Parity bit SHALL be XOR of data bits for even, inverted XOR for odd.
REQ-019 States: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE; each transition on bit-period terminal count.
REQ-020 In the last cycle of the final stop bit, s_axis_tready SHALL assert (registered to be high on the following cycle), giving frame length exactly (1+DATA_WIDTH+P+STOP_BITS)*bit period with no idle gap between back-to-back frames.
REQ-021 busy SHALL be low in IDLE and high from the cycle txd first goes low through the last stop-bit cycle; during back-to-back frames busy SHALL remain high except the single IDLE cycle.
REQ-022 Changes on prescale during a frame SHALL have no effect until the next transfer.
REQ-023 s_axis_tdata changes while not handshaking SHALL be ignored.
REQ-024 Bit counter SHALL count to DATA_WIDTH-1 then wrap to 0; the period counter SHALL be 19 bits (16-bit prescale *8) with no overflow.

Reset
REQ-025 While rst high: txd=1, busy=0, s_axis_tready=0, state IDLE, counters 0.
REQ-026 s_axis_tready SHALL be 1 on the first cycle after rst deasserts.
REQ-027 rst mid-frame SHALL abort the frame, txd=1 on the next cycle; the aborted byte SHALL not be resent.

Structure
REQ-028 State encodings and parity-mode constants SHALL live in shared package uart_pkg, reused by the receiver.
REQ-029 Bit-period timing SHALL be a sub-module uart_baud_gen (load, prescale in, terminal-count tick out).

Verification
REQ-030 prescale=1, 8N1, send 0x55 -> txd low cycles 1-8 after handshake, then 1,0,1,0,1,0,1,0 per 8 cycles, stop high; s_axis_tready high again 80 cycles after handshake+1.
REQ-031 tvalid held, 0xA5 then 0x3C, prescale=2 -> second start bit immediately follows first stop bit; each frame 160 cycles; busy low for exactly 1 cycle between.
REQ-032 PARITY=2, send 0x07 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0; frame 11 bits.
REQ-033 prescale 1->4 during data bit 2 -> current frame keeps 8-cycle bits; next frame uses 32-cycle bits.
REQ-034 rst asserted during data bit 3 -> txd=1 and s_axis_tready=0 next cycle; s_axis_tready=1 first cycle after rst released; no residual bits.
REQ-035 prescale=0, STOP_BITS=2, send 0xFF -> 8-cycle bits, two stop bits, frame 88 cycles.
